// File: rtl/regressive_counter_pkg.sv
// regressive_counter_pkg: shared state encoding and BCD constants for the down counter
package regressive_counter_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [3:0] BCD_MAX = 4'd9;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    COUNT = ST_COUNT,
    HOLD = ST_HOLD,
    DONE = ST_DONE
  } state_e;
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return d > BCD_MAX ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler emitting a tick on the edge that completes TICK_DIV enabled cycles
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = enable && !clear && cnt_q == LAST;
    cnt_d = (clear || tick) ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/down_counter_bcd.sv
// down_counter_bcd: two-digit BCD countdown with run/pause, load and done pulse
module down_counter_bcd
  import regressive_counter_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter bit WRAP = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       run,
  output logic [3:0] digit_units,
  output logic [3:0] digit_tens,
  output logic       zero,
  output logic       done,
  output logic       busy
);
  state_e state_q, state_d;
  logic [3:0] units_q, units_d, tens_q, tens_d, ld_units, ld_tens;
  logic done_q, done_d, tick, last, cnt_en;
  // HOLD with run=1 counts on its resume edge, so a pause never costs a prescaler cycle
  assign cnt_en = run && (state_q == COUNT || state_q == HOLD);
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(load),
    .enable(cnt_en),
    .tick(tick)
  );
  always_comb begin
    ld_units = bcd_clamp(load_value[3:0]);
    ld_tens = bcd_clamp(load_value[7:4]);
    last = tick && tens_q == 4'd0 && units_q == 4'd1;
    units_d = load ? ld_units : tick ? (units_q == 4'd0 ? BCD_MAX : units_q - 1'b1) : units_q;
    tens_d = load ? ld_tens : (tick && units_q == 4'd0) ? (tens_q == 4'd0 ? BCD_MAX : tens_q - 1'b1) : tens_q;
    done_d = last;
    state_d = load ? ((ld_units == 4'd0 && ld_tens == 4'd0) ? DONE : IDLE)
      : state_q == IDLE ? (zero ? DONE : run ? COUNT : IDLE)
      : state_q == DONE ? DONE
      : (last && !WRAP) ? DONE
      : run ? COUNT : HOLD;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      units_q <= 4'd0;
      tens_q <= 4'd0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      units_q <= units_d;
      tens_q <= tens_d;
      done_q <= done_d;
    end
  end
  assign digit_units = units_q;
  assign digit_tens = tens_q;
  assign done = done_q;
  assign zero = tens_q == 4'd0 && units_q == 4'd0;
  assign busy = state_q == COUNT;
endmodule

// File: tb/tb_down_counter_bcd.sv
// tb_down_counter_bcd: vector table, corner sequences and random run against a decimal model
module tb_down_counter_bcd;
  localparam int TD = 4;
  localparam int M_IDLE = 0, M_ACT = 1, M_FIN = 2;
  logic clock = 1'b0, reset = 1'b0, load = 1'b0, run = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic [3:0] u0, t0, u1, t1;
  logic z0, dn0, b0, z1, dn1, b1;
  int checks = 0, failures = 0;
  int m_cnt[2], m_ph[2], m_mode[2];
  bit m_run[2], m_done[2];
  typedef struct {
    logic r;
    logic l;
    logic [7:0] lv;
    logic rn;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[20];

  always #5 clock = ~clock;

  down_counter_bcd #(.TICK_DIV(TD), .WRAP(1'b0)) dut0 (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value), .run(run),
    .digit_units(u0), .digit_tens(t0), .zero(z0), .done(dn0), .busy(b0)
  );
  down_counter_bcd #(.TICK_DIV(TD), .WRAP(1'b1)) dut1 (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value), .run(run),
    .digit_units(u1), .digit_tens(t1), .zero(z1), .done(dn1), .busy(b1)
  );

  function automatic logic [10:0] e(int t, int u, bit z, bit d, bit b);
    return {4'(t), 4'(u), z, d, b};
  endfunction

  function automatic logic [10:0] outs(int w);
    return w == 0 ? {t0, u0, z0, dn0, b0} : {t1, u1, z1, dn1, b1};
  endfunction

  function automatic logic [10:0] model_out(int w);
    return e(m_cnt[w] / 10, m_cnt[w] % 10, m_cnt[w] == 0, m_done[w], m_mode[w] == M_ACT && m_run[w]);
  endfunction

  task automatic check(string name, logic [10:0] act, logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got tens=%0d units=%0d zero=%b done=%b busy=%b, expected tens=%0d units=%0d zero=%b done=%b busy=%b",
        name, $time, act[10:7], act[6:3], act[2], act[1], act[0], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Decimal model: count as 0..99, prescaler phase as plain integer
  task automatic model_step(int w);
    int tn, un;
    m_done[w] = 1'b0;
    if (reset) begin
      m_cnt[w] = 0; m_ph[w] = 0; m_mode[w] = M_IDLE; m_run[w] = 1'b0;
    end else if (load) begin
      tn = int'(load_value[7:4]); un = int'(load_value[3:0]);
      m_cnt[w] = (tn > 9 ? 9 : tn) * 10 + (un > 9 ? 9 : un);
      m_ph[w] = 0;
      m_mode[w] = m_cnt[w] == 0 ? M_FIN : M_IDLE;
    end else if (m_mode[w] == M_IDLE) begin
      m_mode[w] = m_cnt[w] == 0 ? M_FIN : run ? M_ACT : M_IDLE;
      m_run[w] = run;
    end else if (m_mode[w] == M_ACT) begin
      m_run[w] = run;
      if (run) begin
        m_ph[w] = m_ph[w] + 1;
        if (m_ph[w] == TD) begin
          m_ph[w] = 0;
          if (m_cnt[w] == 1) begin
            m_done[w] = 1'b1;
            if (w == 0) m_mode[w] = M_FIN;
          end
          m_cnt[w] = (m_cnt[w] + 99) % 100;
        end
      end
    end
  endtask

  task automatic drive(logic r, logic l, logic [7:0] lv, logic rn);
    reset = r; load = l; load_value = lv; run = rn;
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    check("model_wrap0", outs(0), model_out(0));
    check("model_wrap1", outs(1), model_out(1));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, e(0, 0, 1, 0, 0)};
    tbl[1]  = '{1'b0, 1'b1, 8'h3C, 1'b0, e(3, 9, 0, 0, 0)};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, e(3, 9, 0, 0, 0)};
    tbl[3]  = '{1'b0, 1'b1, 8'h10, 1'b0, e(1, 0, 0, 0, 0)};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, e(1, 0, 0, 0, 1)};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, e(1, 0, 0, 0, 1)};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, e(1, 0, 0, 0, 1)};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, e(1, 0, 0, 0, 1)};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, e(0, 9, 0, 0, 1)};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, e(0, 0, 1, 0, 0)};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, e(0, 0, 1, 0, 0)};
    tbl[11] = '{1'b0, 1'b1, 8'hFF, 1'b0, e(9, 9, 0, 0, 0)};
    tbl[12] = '{1'b1, 1'b1, 8'h55, 1'b1, e(0, 0, 1, 0, 0)};
    tbl[13] = '{1'b0, 1'b1, 8'h01, 1'b0, e(0, 1, 0, 0, 0)};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, e(0, 1, 0, 0, 1)};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, e(0, 1, 0, 0, 1)};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, e(0, 1, 0, 0, 1)};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, e(0, 1, 0, 0, 1)};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b1, e(0, 0, 1, 1, 0)};
    tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b1, e(0, 0, 1, 0, 0)};
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r, tbl[i].l, tbl[i].lv, tbl[i].rn);
      check($sformatf("vec%0d", i), outs(0), tbl[i].exp);
    end

    // Full run from 23 down to 00
    drive(1, 0, 8'h00, 0);
    check("reset_state", outs(0), e(0, 0, 1, 0, 0));
    drive(0, 1, 8'h23, 0);
    drive(0, 0, 8'h00, 1);
    check("run_entry", outs(0), e(2, 3, 0, 0, 1));
    for (int i = 1; i <= 92; i++) begin
      drive(0, 0, 8'h00, 1);
      if (i == 3) check("run_pre_first_tick", outs(0), e(2, 3, 0, 0, 1));
      if (i == 4) check("run_first_tick", outs(0), e(2, 2, 0, 0, 1));
      if (i == 91) check("run_at_01", outs(0), e(0, 1, 0, 0, 1));
      if (i == 92) check("run_reach_00", outs(0), e(0, 0, 1, 1, 0));
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 8'h00, 1);
      check("run_done_hold", outs(0), e(0, 0, 1, 0, 0));
    end

    // Pause two cycles into a tick
    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'h50, 0);
    drive(0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 8'h00, 1);
    check("pause_pre", outs(0), e(4, 9, 0, 0, 1));
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 8'h00, 0);
      check("pause_frozen", outs(0), e(4, 9, 0, 0, 0));
    end
    drive(0, 0, 8'h00, 1);
    check("pause_resume1", outs(0), e(4, 9, 0, 0, 1));
    drive(0, 0, 8'h00, 1);
    check("pause_resume2", outs(0), e(4, 8, 0, 0, 1));

    // Wrap instance: 01 -> 00 -> 99
    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'h01, 0);
    drive(0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 1);
    check("wrap_pre", outs(1), e(0, 1, 0, 0, 1));
    drive(0, 0, 8'h00, 1);
    check("wrap_done", outs(1), e(0, 0, 1, 1, 1));
    drive(0, 0, 8'h00, 1);
    check("wrap_after_done", outs(1), e(0, 0, 1, 0, 1));
    for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 1);
    check("wrap_99", outs(1), e(9, 9, 0, 0, 1));

    // Load coincident with a tick, then reset mid-count
    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'h23, 0);
    drive(0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 1);
    drive(0, 1, 8'h50, 1);
    check("load_on_tick", outs(0), e(5, 0, 0, 0, 0));
    drive(0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 1);
    check("load_prescaler_cleared", outs(0), e(5, 0, 0, 0, 1));
    drive(0, 0, 8'h00, 1);
    check("load_then_tick", outs(0), e(4, 9, 0, 0, 1));
    drive(0, 1, 8'h37, 0);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 1);
    drive(1, 1, 8'h42, 1);
    check("reset_mid_count", outs(0), e(0, 0, 1, 0, 0));
    drive(0, 0, 8'h00, 1);
    check("reset_no_done", outs(0), e(0, 0, 1, 0, 0));

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] lv;
      lv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0, lv, $urandom_range(0, 99) < 85);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
